alu_irq_ctrl: RTL and testbench
===============================

Name: alu_irq_ctrl

Overview:
- Downstream interrupt-service stage for the ALU.
- Watches alu_irq and captures the ALU result plus an operation tag into an event FIFO.
- Drives alu_irq_clr back to the ALU to acknowledge the interrupt, and hands captured events to a host through a valid/ready port.
- Keeps saturating interrupt and drop counters and a sticky stuck-interrupt error.

Parameters:
- DEPTH, 4, event FIFO entries; power of two, at least 2.
- CLR_CYCLES, 1, cycles alu_irq_clr is held high per acknowledge; range 1..15.
- STUCK_LIMIT, 16, WAIT_LOW cycles with alu_irq still high before stuck_err is set.
- THRESH, 2, FIFO level at or above which host_irq asserts; range 1..DEPTH.

Ports:
- alu_clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_irq  in  1  ALU interrupt request.
- alu_out  in  8  ALU result.
- alu_enable_a  in  1  ALU mode A enable, used for tagging.
- alu_enable_b  in  1  ALU mode B enable, used for tagging.
- alu_op_a  in  2  ALU mode A opcode.
- alu_op_b  in  2  ALU mode B opcode.
- alu_irq_clr  out  1  interrupt clear to the ALU; registered.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  host accepts the head.
- evt_data  out  11  {mode, op[1:0], result[7:0]}.
- fifo_level  out  $clog2(DEPTH+1)  current occupancy.
- host_irq  out  1  high while fifo_level >= THRESH.
- irq_count  out  16  interrupts captured; saturates at 16'hFFFF.
- drop_count  out  8  events lost to a full FIFO; saturates at 8'hFF.
- stuck_err  out  1  sticky; cleared only by rst.

Behaviour:
- Reset: FSM=IDLE. FIFO empty. Counters 0. alu_irq_clr=0, evt_valid=0, evt_data=0, host_irq=0, stuck_err=0. Outputs go low immediately on rst assertion (asynchronous), including mid-CLEAR.
- Tag on capture:
  - If alu_enable_a && !alu_enable_b: mode=0, op=alu_op_a.
  - Otherwise: mode=1, op=alu_op_b.
  - result=alu_out sampled on the same edge alu_irq is seen high.
- FSM IDLE:
  - Edge with alu_irq=1: capture the record and increment irq_count (saturating).
  - If FIFO not full, or full with a pop on the same edge: push. Otherwise drop and increment drop_count (saturating).
  - Next state is CLEAR.
- FSM CLEAR:
  - alu_irq_clr=1 for exactly CLR_CYCLES consecutive cycles, starting the cycle after capture. No captures in this state.
  - Then go to WAIT_LOW.
- FSM WAIT_LOW:
  - alu_irq=0: go to IDLE; a new capture is possible on the next edge.
  - alu_irq=1: increment a cycle counter. When it reaches STUCK_LIMIT, set stuck_err and remain in WAIT_LOW.
  - No re-capture of a level-held irq, ever.
- Capture-to-clear latency: 1 cycle. Minimum spacing between captures: CLR_CYCLES+2 cycles.
- FIFO:
  - First-word-fall-through: evt_data = head whenever evt_valid=1. evt_data holds its last value while empty.
  - Pop occurs when evt_valid && evt_ready.
  - Push into an empty FIFO: evt_valid rises the cycle after the push edge (no bypass).
  - Simultaneous push and pop: fifo_level unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
- host_irq is registered from fifo_level and updates the same edge the level changes.
- evt_ready while empty: ignored.

Test Plan:
- Single event: rst pulse; alu_enable_a=1, alu_enable_b=0, alu_op_a=2'b00, alu_out=8'hFF, alu_irq high for 1 cycle → alu_irq_clr high exactly 1 cycle (the cycle after capture); evt_valid=1 next cycle; evt_data=11'h0FF; irq_count=1.
- Mode B tag, CLR_CYCLES=3: alu_enable_b=1, alu_op_b=2'b11, alu_out=8'hFF, irq held 2 cycles → alu_irq_clr high 3 cycles; evt_data=11'h7FF; one capture only.
- Overflow: 6 interrupts with evt_ready=0, DEPTH=4 → fifo_level=4; drop_count=2; host_irq=1 from level 2; pop order returns events 1..4.
- Full plus simultaneous pop: FIFO full, evt_ready=1 on the same edge as a new capture → drop_count unchanged; fifo_level stays 4; new event is last out.
- Stuck irq: alu_irq held high 20 cycles after clear → stuck_err=1 at the 16th WAIT_LOW cycle; irq_count=1; irq low returns FSM to IDLE.
- Reset mid-CLEAR with CLR_CYCLES=3: rst asserted in the 2nd clear cycle → alu_irq_clr low immediately; FIFO empty; counters 0.

Source files
------------

// File: rtl/alu_irq_ctrl.sv
// Interrupt-service stage for the ALU: captures tagged results into an event FIFO,
// acknowledges via alu_irq_clr, and keeps saturating counters plus a stuck-irq flag.
module alu_irq_ctrl #(
    parameter int DEPTH       = 4,
    parameter int CLR_CYCLES  = 1,
    parameter int STUCK_LIMIT = 16,
    parameter int THRESH      = 2
) (
    input  logic                         alu_clk,
    input  logic                         rst,
    input  logic                         alu_irq,
    input  logic [7:0]                   alu_out,
    input  logic                         alu_enable_a,
    input  logic                         alu_enable_b,
    input  logic [1:0]                   alu_op_a,
    input  logic [1:0]                   alu_op_b,
    output logic                         alu_irq_clr,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [10:0]                  evt_data,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         host_irq,
    output logic [15:0]                  irq_count,
    output logic [7:0]                   drop_count,
    output logic                         stuck_err
);
    localparam int LW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STUCK_LIMIT+1);
    localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH_LVL = LW'(THRESH);
    localparam logic [3:0]    CLR_LAST   = 4'(CLR_CYCLES-1);
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_LIMIT-1);
    localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_WAIT_LOW} state_t;

    state_t          r_state, w_state_next;
    logic [3:0]      r_clr_cnt;
    logic [SW-1:0]   r_stuck_cnt;
    logic            r_irq_clr, r_stuck_err, r_host_irq;
    logic            w_capture, w_clr_next, w_stuck_hit;

    logic [10:0]     r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_next;
    logic [LW-1:0]   r_level, w_level_next;
    logic [10:0]     r_evt_data, w_rec;
    logic [15:0]     r_irq_count;
    logic [7:0]      r_drop_count;
    logic            w_full, w_pop, w_push, w_drop, w_mode;
    logic [1:0]      w_op;

    // FSM state register
    always_ff @(posedge alu_clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_clr_cnt   <= '0;
            r_stuck_cnt <= '0;
            r_irq_clr   <= 1'b0;
            r_stuck_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_irq_clr <= w_clr_next;
            r_clr_cnt <= (r_state == S_CLEAR) ? r_clr_cnt + 4'd1 : 4'd0;
            if (r_state == S_WAIT_LOW && alu_irq) begin
                if (r_stuck_cnt != STUCK_MAX)
                    r_stuck_cnt <= r_stuck_cnt + SW'(1);
            end else begin
                r_stuck_cnt <= '0;
            end
            if (w_stuck_hit)
                r_stuck_err <= 1'b1;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (alu_irq) w_state_next = S_CLEAR;
            S_CLEAR:    if (r_clr_cnt == CLR_LAST) w_state_next = S_WAIT_LOW;
            S_WAIT_LOW: if (!alu_irq) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs; alu_irq_clr is registered from the upcoming state
    always_comb begin
        w_capture   = (r_state == S_IDLE) && alu_irq;
        w_clr_next  = (w_state_next == S_CLEAR);
        w_stuck_hit = (r_state == S_WAIT_LOW) && alu_irq && (r_stuck_cnt == STUCK_LAST);
    end

    always_comb begin
        w_mode = !(alu_enable_a && !alu_enable_b);
        w_op   = w_mode ? alu_op_b : alu_op_a;
        w_rec  = {w_mode, w_op, alu_out};
    end

    assign w_full    = (r_level == FULL_LVL);
    assign w_pop     = evt_valid && evt_ready;
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && !w_push;
    assign w_rd_next = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop)
            w_level_next = r_level + LW'(1);
        else if (w_pop && !w_push)
            w_level_next = r_level - LW'(1);
    end

    always_ff @(posedge alu_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_rec;
    end

    // evt_data is a registered copy of the next head, so it simply holds when empty
    always_ff @(posedge alu_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_evt_data   <= '0;
            r_host_irq   <= 1'b0;
            r_irq_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            r_rd_ptr   <= w_rd_next;
            r_level    <= w_level_next;
            r_host_irq <= (w_level_next >= THRESH_LVL);
            if (w_level_next != '0)
                r_evt_data <= (w_push && r_wr_ptr == w_rd_next) ? w_rec : r_mem[w_rd_next];
            if (w_capture && r_irq_count != 16'hFFFF)
                r_irq_count <= r_irq_count + 16'd1;
            if (w_drop && r_drop_count != 8'hFF)
                r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign alu_irq_clr = r_irq_clr;
    assign evt_valid   = (r_level != '0);
    assign evt_data    = r_evt_data;
    assign fifo_level  = r_level;
    assign host_irq    = r_host_irq;
    assign irq_count   = r_irq_count;
    assign drop_count  = r_drop_count;
    assign stuck_err   = r_stuck_err;
endmodule

// File: tb/tb_alu_irq_ctrl.sv
// Directed bench: dut1 uses CLR_CYCLES=1, dut3 uses CLR_CYCLES=3; both share stimulus.
module tb_alu_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_irq, evt_ready, en_a, en_b;
    logic [7:0]  alu_out;
    logic [1:0]  op_a, op_b;

    logic        clr1, valid1, hirq1, stuck1;
    logic [10:0] data1;
    logic [2:0]  lvl1;
    logic [15:0] icnt1;
    logic [7:0]  dcnt1;
    logic        clr3, valid3, hirq3, stuck3;
    logic [10:0] data3;
    logic [2:0]  lvl3;
    logic [15:0] icnt3;
    logic [7:0]  dcnt3;

    int total = 0;
    int bad   = 0;

    logic [10:0] exp_ovf [4] = '{11'h101, 11'h202, 11'h303, 11'h004};
    logic [10:0] exp_full[4] = '{11'h212, 11'h313, 11'h014, 11'h155};

    always #5 clk = ~clk;

    alu_irq_ctrl #(.DEPTH(4), .CLR_CYCLES(1), .STUCK_LIMIT(16), .THRESH(2)) dut1 (
        .alu_clk(clk), .rst(rst), .alu_irq(alu_irq), .alu_out(alu_out),
        .alu_enable_a(en_a), .alu_enable_b(en_b), .alu_op_a(op_a), .alu_op_b(op_b),
        .alu_irq_clr(clr1), .evt_valid(valid1), .evt_ready(evt_ready), .evt_data(data1),
        .fifo_level(lvl1), .host_irq(hirq1), .irq_count(icnt1), .drop_count(dcnt1),
        .stuck_err(stuck1)
    );

    alu_irq_ctrl #(.DEPTH(4), .CLR_CYCLES(3), .STUCK_LIMIT(16), .THRESH(2)) dut3 (
        .alu_clk(clk), .rst(rst), .alu_irq(alu_irq), .alu_out(alu_out),
        .alu_enable_a(en_a), .alu_enable_b(en_b), .alu_op_a(op_a), .alu_op_b(op_b),
        .alu_irq_clr(clr3), .evt_valid(valid3), .evt_ready(evt_ready), .evt_data(data3),
        .fifo_level(lvl3), .host_irq(hirq3), .irq_count(icnt3), .drop_count(dcnt3),
        .stuck_err(stuck3)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s got=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // one capture on the first edge, then two edges to return to IDLE (dut1 spacing)
    task automatic fire(input logic [7:0] d, input logic [1:0] op);
        alu_out = d;
        op_a    = op;
        alu_irq = 1'b1;
        tick();
        alu_irq = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; alu_irq = 1'b0; evt_ready = 1'b0;
        en_a = 1'b1; en_b = 1'b0; op_a = 2'b00; op_b = 2'b00; alu_out = 8'h00;
        tick();
        tick();
        check("rst_clr",   {15'd0, clr1},   16'd0);
        check("rst_valid", {15'd0, valid1}, 16'd0);
        check("rst_data",  {5'd0, data1},   16'd0);
        check("rst_level", {13'd0, lvl1},   16'd0);
        check("rst_hirq",  {15'd0, hirq1},  16'd0);
        check("rst_icnt",  icnt1,           16'd0);
        check("rst_stuck", {15'd0, stuck1}, 16'd0);
        rst = 1'b0;
        tick();

        // single event, mode A
        alu_out = 8'hFF; alu_irq = 1'b1;
        tick();
        alu_irq = 1'b0;
        check("single_clr1",  {15'd0, clr1},   16'd1);
        check("single_valid", {15'd0, valid1}, 16'd1);
        check("single_data",  {5'd0, data1},   16'h0FF);
        check("single_icnt",  icnt1,           16'd1);
        tick();
        check("single_clr0",  {15'd0, clr1},   16'd0);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("pop_empty",    {15'd0, valid1}, 16'd0);
        check("hold_data",    {5'd0, data1},   16'h0FF);

        // mode B tag with a 3-cycle clear, irq held for 2 edges
        rst_pulse();
        en_a = 1'b0; en_b = 1'b1; op_b = 2'b11; alu_out = 8'hFF; alu_irq = 1'b1;
        tick();
        check("b_clr_c1", {15'd0, clr3}, 16'd1);
        tick();
        alu_irq = 1'b0;
        check("b_clr_c2", {15'd0, clr3}, 16'd1);
        tick();
        check("b_clr_c3", {15'd0, clr3}, 16'd1);
        tick();
        check("b_clr_off", {15'd0, clr3}, 16'd0);
        tick();
        tick();
        check("b_icnt",  icnt3,          16'd1);
        check("b_level", {13'd0, lvl3},  16'd1);
        check("b_data",  {5'd0, data3},  16'h7FF);

        // overflow: 6 captures, no reads
        rst_pulse();
        en_a = 1'b1; en_b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            fire(8'(k), 2'(k));
            check("ovf_hirq", {15'd0, hirq1}, (k >= 2) ? 16'd1 : 16'd0);
        end
        check("ovf_level", {13'd0, lvl1}, 16'd4);
        check("ovf_drop",  {8'd0, dcnt1}, 16'd2);
        check("ovf_icnt",  icnt1,         16'd6);
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("ovf_order", {5'd0, data1}, {5'd0, exp_ovf[k]});
            tick();
        end
        evt_ready = 1'b0;
        check("ovf_drained", {13'd0, lvl1},  16'd0);
        check("ovf_hirq0",   {15'd0, hirq1}, 16'd0);

        // full FIFO with a pop on the capture edge
        rst_pulse();
        for (int k = 1; k <= 4; k++)
            fire(8'h10 + 8'(k), 2'(k));
        alu_out = 8'h55; op_a = 2'b01; alu_irq = 1'b1; evt_ready = 1'b1;
        tick();
        alu_irq = 1'b0; evt_ready = 1'b0;
        check("fp_drop",  {8'd0, dcnt1}, 16'd0);
        check("fp_level", {13'd0, lvl1}, 16'd4);
        check("fp_icnt",  icnt1,         16'd5);
        tick();
        tick();
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("fp_order", {5'd0, data1}, {5'd0, exp_full[k]});
            tick();
        end
        evt_ready = 1'b0;

        // stuck interrupt
        rst_pulse();
        alu_irq = 1'b1;
        tick();
        tick();
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n == 15) check("stuck_pre", {15'd0, stuck1}, 16'd0);
            if (n == 16) check("stuck_set", {15'd0, stuck1}, 16'd1);
        end
        for (int n = 0; n < 4; n++)
            tick();
        check("stuck_icnt", icnt1, 16'd1);
        alu_irq = 1'b0;
        tick();
        alu_irq = 1'b1;
        tick();
        alu_irq = 1'b0;
        check("stuck_recap", icnt1,           16'd2);
        check("stuck_clr",   {15'd0, clr1},   16'd1);
        check("stuck_keep",  {15'd0, stuck1}, 16'd1);
        tick();
        tick();

        // reset during the second clear cycle of dut3
        rst_pulse();
        alu_irq = 1'b1;
        tick();
        alu_irq = 1'b0;
        tick();
        check("mid_clr_on", {15'd0, clr3}, 16'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_clr_off", {15'd0, clr3},   16'd0);
        check("mid_level",   {13'd0, lvl3},   16'd0);
        check("mid_valid",   {15'd0, valid3}, 16'd0);
        check("mid_icnt",    icnt3,           16'd0);
        check("mid_drop",    {8'd0, dcnt3},   16'd0);
        rst = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
